// File: rtl/seq_serializer.sv
// Parallel-to-serial frame shifter, MSB first; optional even-parity bit when SER_PARITY_EN is defined.
// Latency: first bit one cycle after transfer; din_ready only in IDLE and the final-bit cycle, enabling gapless frames.
module seq_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             last_q, last_d;
    logic             final_bit;
    logic             xfer;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        x_valid_d = x_valid_q;
        last_d    = last_q;
`ifdef SER_PARITY_EN
        par_d     = par_q;
        final_bit = (state_q == PARITY);
`else
        final_bit = (state_q == SHIFT) && (cnt_q == '0);
`endif
        din_ready = !rst && ((state_q == IDLE) || final_bit);
        xfer      = din_valid && din_ready;

        if (xfer) begin
            state_d   = SHIFT;
            x_d       = din[WIDTH-1];
            x_valid_d = 1'b1;
            last_d    = 1'b0;
            sh_d      = din << 1;
            cnt_d     = CW'(WIDTH - 1);
`ifdef SER_PARITY_EN
            par_d     = ^din;
`endif
        end else if ((state_q == SHIFT) && (cnt_q != '0)) begin
            x_d   = sh_q[WIDTH-1];
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - 1'b1;
`ifdef SER_PARITY_EN
            last_d = 1'b0;
`else
            last_d = (cnt_q == CW'(1));
`endif
`ifdef SER_PARITY_EN
        end else if (state_q == SHIFT) begin
            // data exhausted: append the parity bit as the frame's final bit
            state_d = PARITY;
            x_d     = par_q;
            last_d  = 1'b1;
`endif
        end else if (final_bit) begin
            state_d   = IDLE;
            x_d       = 1'b0;
            x_valid_d = 1'b0;
            last_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            cnt_q     <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            last_q    <= 1'b0;
`ifdef SER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            last_q    <= last_d;
`ifdef SER_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign last    = last_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer (WIDTH=8): queue-based frame model checked every cycle, plus literal frame checks.
module tb_seq_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         x, x_valid, last;

    int checks = 0;
    int errors = 0;

    seq_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .x_valid   (x_valid),
        .last      (last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected bit k of a frame carrying byte v; par is the hand-computed parity literal
    function automatic logic lit_bit(input logic [7:0] v, input int k, input logic par);
        logic [7:0] t;
        t = v;
        return (k < 8) ? t[7-k] : par;
    endfunction

    // Reference model: queue of {last,bit} still to appear on x, head = bit on x now
    logic [1:0] q[$];
    bit armed = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                armed = 1;
            end else begin
                bit take;
                take = din_valid && (q.size() <= 1);
                if (q.size() > 0) void'(q.pop_front());
                if (take) begin
                    for (int k = 0; k < FL; k++) begin
                        logic b;
                        b = (k < W) ? din[W-1-k] : ^din;
                        q.push_back({(k == FL - 1), b});
                    end
                end
            end
            #1;
            if (armed) begin
                chk("model_x_valid", {31'd0, x_valid}, {31'd0, (q.size() > 0)});
                chk("model_x", {31'd0, x}, {31'd0, (q.size() > 0) ? q[0][0] : 1'b0});
                chk("model_last", {31'd0, last}, {31'd0, (q.size() > 0) ? q[0][1] : 1'b0});
            end
            @(negedge clk);
            #2;
            if (armed)
                chk("model_din_ready", {31'd0, din_ready}, {31'd0, (!rst && q.size() <= 1)});
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_x", {31'd0, x}, 32'd0);
        chk("reset_x_valid", {31'd0, x_valid}, 32'd0);
        chk("reset_last", {31'd0, last}, 32'd0);
        chk("reset_din_ready", {31'd0, din_ready}, 32'd1);

        // single frame B6
        din = 8'hB6; din_valid = 1'b1;
        for (int k = 0; k < FL; k++) begin
            @(posedge clk); #1;
            if (k == 0) din_valid = 1'b0;
            chk("b6_x", {31'd0, x}, {31'd0, lit_bit(8'hB6, k, 1'b1)});
            chk("b6_valid", {31'd0, x_valid}, 32'd1);
            chk("b6_last", {31'd0, last}, {31'd0, (k == FL - 1)});
        end
        @(posedge clk); #1;
        chk("b6_end_valid", {31'd0, x_valid}, 32'd0);
        chk("b6_end_x", {31'd0, x}, 32'd0);

        // back-to-back A5 then 3C
        din = 8'hA5; din_valid = 1'b1;
        for (int i = 0; i < 2 * FL; i++) begin
            @(posedge clk); #1;
            if (i == 0) din = 8'h3C;
            if (i == FL) din_valid = 1'b0;
            chk("b2b_x", {31'd0, x},
                {31'd0, (i < FL) ? lit_bit(8'hA5, i, 1'b0) : lit_bit(8'h3C, i - FL, 1'b0)});
            chk("b2b_valid", {31'd0, x_valid}, 32'd1);
            chk("b2b_last", {31'd0, last}, {31'd0, (i == FL - 1) || (i == 2 * FL - 1)});
            if (i == 2) chk("b2b_busy_ready", {31'd0, din_ready}, 32'd0);
            if (i == FL - 1) chk("b2b_final_ready", {31'd0, din_ready}, 32'd1);
        end
        @(posedge clk); #1;
        chk("b2b_end_valid", {31'd0, x_valid}, 32'd0);

        // busy hold: FF offered at bit 3 of 0F
        din = 8'h0F; din_valid = 1'b1;
        for (int i = 0; i < 2 * FL; i++) begin
            @(posedge clk); #1;
            if (i == 0) din_valid = 1'b0;
            if (i == FL) din_valid = 1'b0;
            chk("busy_x", {31'd0, x},
                {31'd0, (i < FL) ? lit_bit(8'h0F, i, 1'b0) : lit_bit(8'hFF, i - FL, 1'b0)});
            chk("busy_valid", {31'd0, x_valid}, 32'd1);
            if (i == 3) begin din = 8'hFF; din_valid = 1'b1; #1; end
            if (i >= 3 && i < FL - 1) chk("busy_ready_low", {31'd0, din_ready}, 32'd0);
            if (i == FL - 1) chk("busy_ready_final", {31'd0, din_ready}, 32'd1);
        end
        @(posedge clk); #1;
        chk("busy_end_valid", {31'd0, x_valid}, 32'd0);

        // reset mid-frame with a simultaneous transfer attempt
        din = 8'hB6; din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 0) din_valid = 1'b0;
        end
        chk("rst_mid_x", {31'd0, x}, {31'd0, lit_bit(8'hB6, 3, 1'b1)});
        rst = 1'b1; din = 8'hC3; din_valid = 1'b1;
        #1 chk("rst_ready_low", {31'd0, din_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rst_x", {31'd0, x}, 32'd0);
        chk("rst_valid", {31'd0, x_valid}, 32'd0);
        chk("rst_last", {31'd0, last}, 32'd0);
        rst = 1'b0; din_valid = 1'b0;
        #1 chk("rst_ready_after", {31'd0, din_ready}, 32'd1);
        @(posedge clk); #1;
        chk("rst_idle_valid", {31'd0, x_valid}, 32'd0);

        // randomized traffic with occasional resets, checked by the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            din       = W'($urandom);
            din_valid = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b1; din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
